// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer/count/flag controller for an external 2**ADDR_WIDTH register file.
// Ports: clk, reset, wr, rd, clr_err in; w_en, w_addr, r_addr, full, empty, almost_full, count, overflow, underflow out.
module fifo_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int AF_LEVEL   = (2 ** ADDR_WIDTH) - 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic                  rd,
    input  logic                  clr_err,
    output logic                  w_en,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [ADDR_WIDTH-1:0] r_addr,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH + 1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] ONE_C   = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] ONE_A = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
    logic [ADDR_WIDTH-1:0] r_addr_q, r_addr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  push, pop;
    logic                  full_c, empty_c;
    logic                  ovf_set, udf_set;

    assign full_c  = (count_q == DEPTH_C);
    assign empty_c = (count_q == '0);

    always_comb begin
        pop         = 1'b0;
        push        = 1'b0;
        ovf_set     = 1'b0;
        udf_set     = 1'b0;
        w_addr_d    = w_addr_q;
        r_addr_d    = r_addr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        // A pop frees a slot in the same cycle, so a push into a full
        // FIFO is still accepted when paired with a valid pop.
        pop     = rd & ~empty_c & ~reset;
        push    = wr & (~full_c | pop) & ~reset;
        ovf_set = wr & full_c & ~pop;
        udf_set = rd & empty_c;

        if (push) w_addr_d = w_addr_q + ONE_A;
        if (pop)  r_addr_d = r_addr_q + ONE_A;

        unique case ({push, pop})
            2'b10:   count_d = count_q + ONE_C;
            2'b01:   count_d = count_q - ONE_C;
            default: count_d = count_q;
        endcase

        // A new error in the clearing cycle wins over the clear.
        if (clr_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (ovf_set) overflow_d  = 1'b1;
        if (udf_set) underflow_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_addr_q    <= '0;
            r_addr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            w_addr_q    <= w_addr_d;
            r_addr_q    <= r_addr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign w_en        = push;
    assign w_addr      = w_addr_q;
    assign r_addr      = r_addr_q;
    assign count       = count_q;
    assign full        = full_c;
    assign empty       = empty_c;
    assign almost_full = (count_q >= AF_C);
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;

endmodule
